// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags.
// Reads are combinational with same-cycle commit forwarding. Rename, commit and rollback update state on the edge.
module reg_file_rename #(
    parameter int REG_NUM = 32,
    parameter int TAG_W   = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [4:0]       rs1_from_dispatcher,
    input  logic [4:0]       rs2_from_dispatcher,
    output logic [TAG_W-1:0] Q1_to_dispatcher,
    output logic [TAG_W-1:0] Q2_to_dispatcher,
    output logic [31:0]      V1_to_dispatcher,
    output logic [31:0]      V2_to_dispatcher,
    input  logic             en_signal_from_dispatcher,
    input  logic [4:0]       rd_from_dispatcher,
    input  logic [TAG_W-1:0] rob_id_from_dispatcher,
    input  logic             commit_flag_from_rob,
    input  logic [4:0]       rd_from_rob,
    input  logic [TAG_W-1:0] Q_from_rob,
    input  logic [31:0]      V_from_rob,
    input  logic             rollback_from_rob,
    output logic [5:0]       pending_cnt_out
);

    logic [31:0]      value_q [1:REG_NUM-1];
    logic [TAG_W-1:0] tag_q   [1:REG_NUM-1];
    logic [TAG_W-1:0] tag_d   [1:REG_NUM-1];
    logic [5:0]       cnt_d;

    logic [1:0][4:0]       rs;
    logic [1:0][TAG_W-1:0] q_rd;
    logic [1:0][31:0]      v_rd;

    assign rs[0] = rs1_from_dispatcher;
    assign rs[1] = rs2_from_dispatcher;
    assign Q1_to_dispatcher = q_rd[0];
    assign Q2_to_dispatcher = q_rd[1];
    assign V1_to_dispatcher = v_rd[0];
    assign V2_to_dispatcher = v_rd[1];

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            q_rd[p] = '0;
            v_rd[p] = '0;
            if (rs[p] != 5'd0 && int'(rs[p]) < REG_NUM) begin
                // A committing producer hands its value straight to the reader
                if (commit_flag_from_rob && rd_from_rob == rs[p] && Q_from_rob == tag_q[rs[p]]) begin
                    q_rd[p] = '0;
                    v_rd[p] = V_from_rob;
                end else begin
                    q_rd[p] = tag_q[rs[p]];
                    v_rd[p] = value_q[rs[p]];
                end
            end
        end
    end

    // Next tags: rollback clears all; otherwise rename overrides the commit tag-clear
    always_comb begin
        cnt_d = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            tag_d[i] = tag_q[i];
            if (rollback_from_rob) begin
                tag_d[i] = '0;
            end else begin
                if (commit_flag_from_rob && rd_from_rob == 5'(i) && tag_q[i] == Q_from_rob)
                    tag_d[i] = '0;
                if (en_signal_from_dispatcher && rd_from_dispatcher == 5'(i))
                    tag_d[i] = rob_id_from_dispatcher;
            end
            cnt_d = cnt_d + 6'(tag_d[i] != '0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            pending_cnt_out <= '0;
        end else if (rdy_in) begin
            for (int i = 1; i < REG_NUM; i++) begin
                tag_q[i] <= tag_d[i];
                if (commit_flag_from_rob && rd_from_rob == 5'(i))
                    value_q[i] <= V_from_rob;
            end
            pending_cnt_out <= cnt_d;
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: reset, rename/commit, stale commit, rollback, x0, stall.
module tb_reg_file_rename;

    localparam int TAG_W = 5;

    logic             clk_in = 1'b0;
    logic             rst_in, rdy_in;
    logic [4:0]       rs1, rs2, rd_d, rd_r;
    logic [TAG_W-1:0] q1, q2, rob_id, q_r;
    logic [31:0]      v1, v2, v_r;
    logic             en, commit, rollback;
    logic [5:0]       cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    reg_file_rename #(.REG_NUM(32), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rs1_from_dispatcher(rs1), .rs2_from_dispatcher(rs2),
        .Q1_to_dispatcher(q1), .Q2_to_dispatcher(q2),
        .V1_to_dispatcher(v1), .V2_to_dispatcher(v2),
        .en_signal_from_dispatcher(en), .rd_from_dispatcher(rd_d),
        .rob_id_from_dispatcher(rob_id),
        .commit_flag_from_rob(commit), .rd_from_rob(rd_r), .Q_from_rob(q_r),
        .V_from_rob(v_r), .rollback_from_rob(rollback),
        .pending_cnt_out(cnt)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        en = 0; commit = 0; rollback = 0;
        rd_d = 0; rd_r = 0; rob_id = 0; q_r = 0; v_r = 0;
    endtask

    task automatic ren(input logic [4:0] r, input logic [TAG_W-1:0] t);
        en = 1; rd_d = r; rob_id = t;
    endtask

    task automatic cmt(input logic [4:0] r, input logic [TAG_W-1:0] t, input logic [31:0] v);
        commit = 1; rd_r = r; q_r = t; v_r = v;
    endtask

    initial begin
        quiet();
        rst_in = 0; rdy_in = 1; rs1 = 5; rs2 = 0;
        #3;
        chk("reset_cnt", 32'(cnt), 0);
        chk("reset_q1", 32'(q1), 0);
        chk("reset_v1", v1, 0);
        #9 rst_in = 1;
        step();

        // rename x5 -> 3; same-cycle read still sees old tag
        ren(5, 3); #1;
        chk("ren_same_cycle_q1", 32'(q1), 0);
        step(); quiet(); #1;
        chk("ren_q1", 32'(q1), 3);
        chk("ren_cnt", 32'(cnt), 1);

        cmt(5, 3, 32'hDEADBEEF); #1;
        chk("fwd_q1", 32'(q1), 0);
        chk("fwd_v1", v1, 32'hDEADBEEF);
        step(); quiet(); #1;
        chk("cmt_q1", 32'(q1), 0);
        chk("cmt_v1", v1, 32'hDEADBEEF);
        chk("cmt_cnt", 32'(cnt), 0);

        // stale commit on x7
        rs1 = 7;
        ren(7, 2); step();
        ren(7, 6); step(); quiet();
        cmt(7, 2, 32'h11); #1;
        chk("stale_nofwd_q1", 32'(q1), 6);
        chk("stale_nofwd_v1", v1, 0);
        step(); quiet(); #1;
        chk("stale_q1", 32'(q1), 6);
        chk("stale_v1", v1, 32'h11);
        chk("stale_cnt", 32'(cnt), 1);

        ren(7, 9); cmt(7, 9, 32'h22); step(); quiet(); #1;
        chk("ren9_q1", 32'(q1), 9);
        chk("ren9_v1", v1, 32'h22);

        // matching commit loses the tag to a same-cycle rename
        ren(7, 10); cmt(7, 9, 32'h33); #1;
        chk("prio_fwd_v1", v1, 32'h33);
        step(); quiet(); #1;
        chk("prio_q1", 32'(q1), 10);
        chk("prio_v1", v1, 32'h33);
        cmt(7, 10, 32'h44); step(); quiet(); #1;
        chk("prio_clear_cnt", 32'(cnt), 0);

        // rollback with concurrent commit and rename
        ren(1, 1); step();
        ren(2, 2); step();
        ren(3, 3); step(); quiet();
        rs2 = 2; #1;
        chk("rb_pre_cnt", 32'(cnt), 3);
        chk("rb_pre_q2", 32'(q2), 2);
        rollback = 1; cmt(1, 1, 32'h40); ren(4, 5);
        step(); quiet();
        rs1 = 1; rs2 = 4; #1;
        chk("rb_q1_x1", 32'(q1), 0);
        chk("rb_v1_x1", v1, 32'h40);
        chk("rb_q2_x4", 32'(q2), 0);
        chk("rb_cnt", 32'(cnt), 0);
        rs1 = 3; rs2 = 2; #1;
        chk("rb_q1_x3", 32'(q1), 0);
        chk("rb_q2_x2", 32'(q2), 0);

        // x0 writes ignored
        ren(9, 7); step(); quiet();
        rs1 = 0;
        ren(0, 4); cmt(0, 0, 32'hFFFFFFFF); #1;
        chk("x0_fwd_v1", v1, 0);
        step(); quiet(); #1;
        chk("x0_q1", 32'(q1), 0);
        chk("x0_v1", v1, 0);
        chk("x0_cnt", 32'(cnt), 1);

        // stall: held rename and commit do nothing until rdy rises
        rdy_in = 0; rs1 = 8; rs2 = 9;
        ren(8, 3); cmt(9, 7, 32'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_q1", 32'(q1), 0);
            chk("stall_cnt", 32'(cnt), 1);
            chk("stall_fwd_v2", v2, 32'h55);
        end
        rdy_in = 1;
        step(); quiet(); #1;
        chk("unstall_q1", 32'(q1), 3);
        chk("unstall_q2", 32'(q2), 0);
        chk("unstall_v2", v2, 32'h55);
        chk("unstall_cnt", 32'(cnt), 1);

        // asynchronous reset between edges with a rename in flight
        ren(10, 4); #2;
        rst_in = 0; #1;
        chk("areset_cnt", 32'(cnt), 0);
        chk("areset_q1", 32'(q1), 0);
        chk("areset_v2", v2, 0);
        quiet(); #1 rst_in = 1;
        step();
        rs1 = 5; rs2 = 10; #1;
        chk("post_reset_q1", 32'(q1), 0);
        chk("post_reset_v1", v1, 0);
        chk("post_reset_q2", 32'(q2), 0);
        chk("post_reset_cnt", 32'(cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Architectural register file with per-register rename tags for the Tomasulo core. It sits between the dispatcher, which reads operands and renames destinations, and the reorder buffer, which retires results into it. It is the receiving end of the RoB commit interface: it accepts the commit write and the rollback flag, clears rename tags whose producer has committed, and forwards same-cycle commit data to operand reads.

## Interface
- `REG_NUM`, default 32: number of architectural registers; x0 is hard-wired to zero.
- `TAG_W`, default 5: RoB tag width. Tag 0 means "no pending producer"; RoB entry k is tag k+1.

Ports:
- `clk_in`  in  1  the single clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global ready. When low, all state holds.
- `rs1_from_dispatcher`  in  5  source register 1 index.
- `rs2_from_dispatcher`  in  5  source register 2 index.
- `Q1_to_dispatcher`  out  TAG_W  pending tag for rs1; 0 means the value is valid.
- `Q2_to_dispatcher`  out  TAG_W  pending tag for rs2.
- `V1_to_dispatcher`  out  32  rs1 value; meaningful only when Q1 is 0.
- `V2_to_dispatcher`  out  32  rs2 value; meaningful only when Q2 is 0.
- `en_signal_from_dispatcher`  in  1  an instruction is being issued this cycle.
- `rd_from_dispatcher`  in  5  destination register of the issuing instruction.
- `rob_id_from_dispatcher`  in  TAG_W  RoB tag assigned to the issuing instruction (1..16).
- `commit_flag_from_rob`  in  1  commit write is valid this cycle.
- `rd_from_rob`  in  5  destination register of the committing instruction.
- `Q_from_rob`  in  TAG_W  tag of the committing entry.
- `V_from_rob`  in  32  committed value.
- `rollback_from_rob`  in  1  mispredict flush.
- `pending_cnt_out`  out  6  registered count of registers whose tag is nonzero.

## Operation
- State: `value[1..31]` (32 bits each) and `tag[1..31]` (TAG_W bits each). x0 has no storage.
- Read ports are combinational, evaluated independently for rs1 and rs2:
  - rs = 0: Q = 0, V = 0.
  - Else, if `commit_flag_from_rob` is high, `rd_from_rob` = rs and `Q_from_rob` = tag[rs]: Q = 0, V = `V_from_rob` (forwarding).
  - Else: Q = tag[rs], V = value[rs].
- Forwarding applies regardless of `rdy_in` and `rollback_from_rob`.
- All updates below happen on the clock edge, and only when `rdy_in` = 1 and reset is deasserted.
- Commit, when `commit_flag_from_rob` = 1 and `rd_from_rob` ≠ 0:
  - value[rd] <= `V_from_rob`, unconditionally.
  - tag[rd] <= 0 only if tag[rd] == `Q_from_rob` and no rename to the same rd wins this cycle.
- Rename, when `en_signal_from_dispatcher` = 1, `rd_from_dispatcher` ≠ 0 and `rollback_from_rob` = 0: tag[rd] <= `rob_id_from_dispatcher`.
- Priority on the same rd: rename beats the commit tag-clear. The commit value write still occurs.
- Rollback, when `rollback_from_rob` = 1:
  - All tags <= 0.
  - A concurrent commit still writes its value, because the branch itself commits in the rollback cycle.
  - A concurrent rename is dropped.
- `pending_cnt_out` equals the number of nonzero tags after each edge (0..31). It is 0 after rollback.
- Writes with rd = 0 from either side are ignored entirely.

## Timing
- Reset (`rst_in` low) takes effect immediately, without waiting for a clock edge:
  - all value and tag entries go to 0;
  - `pending_cnt_out` = 0;
  - read outputs therefore read as Q = 0, V = 0.
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge. A rename or commit on edge N is visible on the read ports from cycle N+1.
- A rename of rd in cycle N followed by a read of rd in cycle N returns the old tag. The dispatcher handles same-cycle dependencies itself.
- When `rdy_in` is low, the edge is ignored: held commit and rename inputs are not applied, and `pending_cnt_out` holds.
- Reset asserted mid-operation discards all pending tags. No partial update of the edge may survive.

## Test plan
- **Reset:** assert `rst_in` = 0 asynchronously between edges -> `pending_cnt_out` = 0 and Q1/V1 = 0/0 for every rs immediately; after release, reads of x5 give Q = 0, V = 0.
- **Rename then commit:**
  - Rename x5 with tag 3 -> next cycle Q1 = 3 and `pending_cnt_out` = 1.
  - Commit rd = 5, Q = 3, V = 0xDEADBEEF -> in the same cycle Q1 = 0 and V1 = 0xDEADBEEF (forwarded); after the edge the register file holds the same and `pending_cnt_out` = 0.
- **Stale commit:**
  - x7 tag = 2, then renamed to tag 6.
  - Commit rd = 7, Q = 2, V = 0x11 -> value[7] = 0x11 but tag stays 6, and a read gives Q = 6.
  - Same-cycle rename x7 -> 9 plus commit of x7 with Q = 9 -> tag = 9 after the edge.
- **Rollback:**
  - Tags set on x1, x2, x3.
  - Rollback together with commit rd = 1, V = 0x40 and rename x4 -> 5 -> all tags 0, value[1] = 0x40, x4 has no tag, `pending_cnt_out` = 0.
- **x0:** rename x0 with tag 4 and commit rd = 0, V = 0xFFFFFFFF -> reads of x0 give Q = 0, V = 0; `pending_cnt_out` unchanged.
- **Stall:** with `rdy_in` = 0, hold a rename of x8 -> 3 for 3 cycles -> no change. Raise `rdy_in` -> tag[8] = 3 after one edge.
